// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//   General-purpose register file with NRD combinational read ports and one
//   write port. It also holds a pending-write scoreboard and a sequencer that
//   clears the array after reset. ID reads operands and marks destinations
//   pending at issue. WB writes results and clears the pending marks. busy[i]
//   tells ID that the operand on port i is not ready yet.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> WB-to-ID forwarding of wdata onto matching read ports, and
//                suppression of busy on a same-cycle writeback hit.
//   undefined -> rdata always comes from the array, and busy ignores the
//                in-flight write.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   init_busy  high while in reset or while the array is being cleared
//   we/waddr/wdata            write port (WB)
//   re/raddr/rdata            per-port read enable/address/data (ID);
//                             port i is at raddr[i*ADDR_W +: ADDR_W] and
//                             rdata[i*DATA_W +: DATA_W]
//   busy                      per-port operand-not-ready flag
//   set_en/set_addr           mark a destination register pending (issue)
//   flush                     drop every pending mark
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        busy,
    input  logic                  set_en,
    input  logic [ADDR_W-1:0]     set_addr,
    input  logic                  flush
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                init_busy_q, init_busy_d;
    logic [DEPTH-1:0]    pend_q, pend_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    logic                run_s;
    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic [ADDR_W-1:0]   rd_addr_s [NRD];
    logic [NRD-1:0]      hit_s;
    logic [NRD*DATA_W-1:0] rdata_s;
    logic [NRD-1:0]      busy_s;

    assign run_s = (state_q == ST_RUN);

    // Sequencer next state: RST -> CLEAR (counter at 1) -> RUN after the last register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_CLEAR;
                cnt_d   = ONE_ADDR;
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = ONE_ADDR;
                end else begin
                    state_d = ST_CLEAR;
                    cnt_d   = cnt_q + ONE_ADDR;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                cnt_d   = cnt_q;
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = ONE_ADDR;
            end
        endcase
        init_busy_d = (state_d != ST_RUN);
    end

    // Array write port: the sequencer owns it during CLEAR, WB owns it during RUN.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = cnt_q;
        wr_data_s = ZERO_DATA;
        if (state_q == ST_CLEAR) begin
            wr_en_s = 1'b1;
        end else if (run_s && we && (waddr != ZERO_ADDR)) begin
            wr_en_s   = 1'b1;
            wr_addr_s = waddr;
            wr_data_s = wdata;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Scoreboard next state: flush beats set, and set beats a same-cycle writeback clear.
    always_comb begin
        pend_d    = {DEPTH{1'b0}};
        pend_d[0] = 1'b0;
        for (int j = 1; j < DEPTH; j++) begin
            if (!run_s || flush) begin
                pend_d[j] = 1'b0;
            end else if (set_en && (set_addr == ADDR_W'(j))) begin
                pend_d[j] = 1'b1;
            end else if (we && (waddr == ADDR_W'(j))) begin
                pend_d[j] = 1'b0;
            end else begin
                pend_d[j] = pend_q[j];
            end
        end
    end

    // Read ports: combinational, gated to zero outside RUN, on re=0, or for r0.
    always_comb begin
        rdata_s = {(NRD*DATA_W){1'b0}};
        busy_s  = {NRD{1'b0}};
        hit_s   = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            rd_addr_s[i] = raddr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
            hit_s[i] = we && (waddr == rd_addr_s[i]);
`else
            hit_s[i] = 1'b0;
`endif
            if (run_s && re[i] && (rd_addr_s[i] != ZERO_ADDR)) begin
                if (hit_s[i]) begin
                    rdata_s[i*DATA_W +: DATA_W] = wdata;
                end else begin
                    rdata_s[i*DATA_W +: DATA_W] = regs_q[rd_addr_s[i]];
                end
                // pend_q is the pre-edge state, so a same-cycle set does not show yet.
                busy_s[i] = pend_q[rd_addr_s[i]] & ~hit_s[i];
            end else begin
                rdata_s[i*DATA_W +: DATA_W] = ZERO_DATA;
                busy_s[i] = 1'b0;
            end
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RST;
            cnt_q       <= ONE_ADDR;
            init_busy_q <= 1'b1;
            pend_q      <= {DEPTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
            pend_q      <= pend_d;
        end
    end

    // Register array storage; contents are established by the CLEAR sequence.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            regs_q[wr_addr_s] <= wr_data_s;
        end
    end

    assign init_busy = init_busy_q;
    assign rdata     = rdata_s;
    assign busy      = busy_s;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        init_busy;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  busy;
    logic        set_en;
    logic [4:0]  set_addr;
    logic        flush;

    int total = 0;
    int bad   = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .init_busy(init_busy),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re       (re),
        .raddr    (raddr),
        .rdata    (rdata),
        .busy     (busy),
        .set_en   (set_en),
        .set_addr (set_addr),
        .flush    (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        se;
        logic [4:0]  sa;
        logic        fl;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] wd,
                                logic [1:0] r, logic [4:0] ra0, logic [4:0] ra1,
                                logic se, logic [4:0] sa, logic fl,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.re = r; v.ra0 = ra0; v.ra1 = ra1;
        v.se = se; v.sa = sa; v.fl = fl; v.e0 = e0; v.e1 = e1; v.eb = eb;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [1:0] r, input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic se, input logic [4:0] sa, input logic fl);
        we = w; waddr = wa; wdata = wd; re = r; raddr = {ra1, ra0};
        set_en = se; set_addr = sa; flush = fl;
    endtask

    int n;

    initial begin
        // Directed vectors, applied from RUN with every register zero and nothing pending.
        vt.push_back(mk(1'b1, 5'd3, 32'hDEADBEEF, 2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0,
                        BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 2'b00));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0,
                        32'hDEADBEEF, 32'hDEADBEEF, 2'b00));
        vt.push_back(mk(1'b1, 5'd0, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0,
                        32'h0, 32'h0, 2'b00));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                        32'h0, 32'h0, 2'b00));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b00, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0,
                        32'h0, 32'h0, 2'b00));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0,
                        32'h0, 32'h0, 2'b00));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0,
                        32'h0, 32'h0, 2'b11));
        vt.push_back(mk(1'b1, 5'd7, 32'h12345678, 2'b11, 5'd7, 5'd3, 1'b0, 5'd0, 1'b0,
                        BYP ? 32'h12345678 : 32'h0, 32'hDEADBEEF, BYP ? 2'b00 : 2'b01));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0,
                        32'h12345678, 32'h0, 2'b00));
        vt.push_back(mk(1'b1, 5'd7, 32'hAAAA5555, 2'b01, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0,
                        BYP ? 32'hAAAA5555 : 32'h12345678, 32'h0, 2'b00));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0,
                        32'hAAAA5555, 32'h0, 2'b01));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b10, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0,
                        32'h0, 32'hAAAA5555, 2'b10));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0,
                        32'h0, 32'h0, 2'b00));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd9, 1'b1, 5'd9, 1'b0,
                        32'h0, 32'h0, 2'b01));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd12, 1'b1, 5'd12, 1'b0,
                        32'h0, 32'h0, 2'b01));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd12, 1'b1, 5'd4, 1'b1,
                        32'h0, 32'h0, 2'b11));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd9, 1'b0, 5'd0, 1'b0,
                        32'h0, 32'h0, 2'b00));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b11, 5'd12, 5'd7, 1'b0, 5'd0, 1'b0,
                        32'h0, 32'hAAAA5555, 2'b00));
        vt.push_back(mk(1'b1, 5'd31, 32'h0F0F0F0F, 2'b01, 5'd31, 5'd0, 1'b0, 5'd0, 1'b0,
                        BYP ? 32'h0F0F0F0F : 32'h0, 32'h0, 2'b00));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b11, 5'd31, 5'd1, 1'b0, 5'd0, 1'b0,
                        32'h0F0F0F0F, 32'h0, 2'b00));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd20, 1'b0,
                        32'h0, 32'h0, 2'b00));
        vt.push_back(mk(1'b1, 5'd21, 32'h00000001, 2'b11, 5'd20, 5'd21, 1'b0, 5'd0, 1'b0,
                        32'h0, BYP ? 32'h00000001 : 32'h0, 2'b01));
        vt.push_back(mk(1'b0, 5'd0, 32'h0, 2'b11, 5'd21, 5'd20, 1'b0, 5'd0, 1'b0,
                        32'h00000001, 32'h0, 2'b10));

        // Reset for three cycles.
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd5, 1'b0, 5'd0, 1'b0);
        repeat (3) tick();
        chk("rst_init_busy", {31'h0, init_busy}, 32'h1);
        chk("rst_rdata0", rdata[31:0], 32'h0);
        chk("rst_rdata1", rdata[63:32], 32'h0);
        chk("rst_busy", {30'h0, busy}, 32'h0);

        // Release; WB write and issue to r5 held throughout CLEAR must be ignored.
        drive(1'b1, 5'd5, 32'hFFFFFFFF, 2'b11, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0);
        rst = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (k == 0) begin
                chk("clear_rdata0", rdata[31:0], 32'h0);
                chk("clear_busy", {30'h0, busy}, 32'h0);
            end
            if (init_busy) n++;
            else break;
        end
        chk("clear_len", n, 32'd31);
        drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

        // Every register reads back zero after CLEAR.
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 2'b11, 5'(i), 5'(32 - i), 1'b0, 5'd0, 1'b0);
            #1;
            chk("cleared_p0", rdata[31:0], 32'h0);
            chk("cleared_p1", rdata[63:32], 32'h0);
        end
        drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("r5_not_pending", {30'h0, busy}, 32'h0);
        tick();

        // Table-driven vectors.
        foreach (vt[idx]) begin
            drive(vt[idx].we, vt[idx].wa, vt[idx].wd, vt[idx].re, vt[idx].ra0, vt[idx].ra1,
                  vt[idx].se, vt[idx].sa, vt[idx].fl);
            #1;
            chk($sformatf("vec%0d_rdata0", idx), rdata[31:0], vt[idx].e0);
            chk($sformatf("vec%0d_rdata1", idx), rdata[63:32], vt[idx].e1);
            chk($sformatf("vec%0d_busy", idx), {30'h0, busy}, {30'h0, vt[idx].eb});
            tick();
        end

        // Reset in RUN: outputs gated, r20 pending mark dropped.
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd20, 1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        tick();
        chk("rst2_init_busy", {31'h0, init_busy}, 32'h1);
        chk("rst2_rdata0", rdata[31:0], 32'h0);
        chk("rst2_busy", {30'h0, busy}, 32'h0);

        // Mid-CLEAR reset restarts the full 31-cycle sequence.
        rst = 1'b1;
        repeat (10) tick();
        chk("midclear_init_busy", {31'h0, init_busy}, 32'h1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (init_busy) n++;
            else break;
        end
        chk("midclear_len", n, 32'd31);
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd20, 1'b0, 5'd0, 1'b0);
        #1;
        chk("reclear_r3", rdata[31:0], 32'h0);
        chk("reclear_busy", {30'h0, busy}, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd31, 5'd7, 1'b0, 5'd0, 1'b0);
        #1;
        chk("reclear_r31", rdata[31:0], 32'h0);
        chk("reclear_r7", rdata[63:32], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
